// File: rtl/iob_ram_t2p_tiled_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iob_ram_t2p_tiled_arb_pkg                                                |
// | Shared encodings for the tiled-RAM two-requester arbiter.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package iob_ram_t2p_tiled_arb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 13;
  localparam int MEM_DEPTH  = 2 ** DEF_ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [0:0] REQ_A = 1'b0;
  localparam logic [0:0] REQ_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/iob_ram_t2p_tiled_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iob_ram_t2p_tiled_arb_if                                                 |
// | Request/response bundle for requesters A and B of the tiled-RAM arbiter. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface iob_ram_t2p_tiled_arb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
);

  logic              a_valid_i;
  logic              a_ready_o;
  logic              a_we_i;
  logic [ADDR_W-1:0] a_addr_i;
  logic [DATA_W-1:0] a_wdata_i;
  logic              a_rvalid_o;
  logic [DATA_W-1:0] a_rdata_o;

  logic              b_valid_i;
  logic              b_ready_o;
  logic              b_we_i;
  logic [ADDR_W-1:0] b_addr_i;
  logic [DATA_W-1:0] b_wdata_i;
  logic              b_rvalid_o;
  logic [DATA_W-1:0] b_rdata_o;

  modport master (
    output a_valid_i, a_we_i, a_addr_i, a_wdata_i,
    input  a_ready_o, a_rvalid_o, a_rdata_o,
    output b_valid_i, b_we_i, b_addr_i, b_wdata_i,
    input  b_ready_o, b_rvalid_o, b_rdata_o
  );

  modport slave (
    input  a_valid_i, a_we_i, a_addr_i, a_wdata_i,
    output a_ready_o, a_rvalid_o, a_rdata_o,
    input  b_valid_i, b_we_i, b_addr_i, b_wdata_i,
    output b_ready_o, b_rvalid_o, b_rdata_o
  );

endinterface
`default_nettype wire

// File: rtl/iob_ram_t2p_tiled_arb_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iob_rr_arb2                                                              |
// | Two-way round-robin grant with a registered priority pointer.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module iob_rr_arb2
  import iob_ram_t2p_tiled_arb_pkg::*;
(
  input  wire logic       clk_i,
  input  wire logic       arst_i,
  input  wire logic       en_i,
  input  wire logic [1:0] req_i,
  output logic      [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) ptr_q <= REQ_A;
    else        ptr_q <= ptr_d;
  end

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) gnt_o[ptr_q] = 1'b1;
      else                gnt_o = req_i;
    end
  end

  // Priority passes to whoever lost (or was idle) on each grant.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[REQ_A])      ptr_d = REQ_B;
    else if (gnt_o[REQ_B]) ptr_d = REQ_A;
  end

endmodule
`default_nettype wire

// File: rtl/iob_ram_t2p_tiled_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iob_ram_t2p_tiled_arb                                                    |
// | Round-robin arbiter for two requesters in front of one tiled RAM.        |
// | Optional power-up zero sweep: IOB_RAM_T2P_TILED_ARB_CLEAR_EN.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module iob_ram_t2p_tiled_arb
  import iob_ram_t2p_tiled_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  wire logic              clk_i,
  input  wire logic              arst_i,
  iob_ram_t2p_tiled_arb_if.slave req,
  output logic                   mem_w_en_o,
  output logic                   mem_r_en_o,
  output logic      [ADDR_W-1:0] mem_addr_o,
  output logic      [DATA_W-1:0] mem_w_data_o,
  input  wire logic [DATA_W-1:0] mem_r_data_i,
  output logic                   init_done_o
);

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic              clearing;
  logic [1:0]        gnt;
  logic [1:0]        rsp_q;
  logic [1:0]        rsp_d;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              clr_last;

`ifdef IOB_RAM_T2P_TILED_ARB_CLEAR_EN
  localparam logic [0:0] ST_RESET = ST_CLEAR;

  logic [ADDR_W-1:0] clr_cnt_d;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) clr_cnt_q <= '0;
    else        clr_cnt_q <= clr_cnt_d;
  end

  assign clr_cnt_d = clearing ? clr_cnt_q + 1'b1 : clr_cnt_q;
  assign clr_last  = (clr_cnt_q == {ADDR_W{1'b1}});
`else
  localparam logic [0:0] ST_RESET = ST_RUN;

  assign clr_cnt_q = '0;
  assign clr_last  = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_last) state_d = ST_RUN;
      default:  state_d = state_q;
    endcase
  end

  iob_rr_arb2 u_rr (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .en_i   (init_done_o),
    .req_i  ({req.b_valid_i, req.a_valid_i}),
    .gnt_o  (gnt)
  );

  always_comb begin
    init_done_o  = (state_q == ST_RUN);
    clearing     = (state_q == ST_CLEAR);
    mem_w_en_o   = 1'b0;
    mem_r_en_o   = 1'b0;
    mem_addr_o   = '0;
    mem_w_data_o = '0;
    if (clearing) begin
      mem_w_en_o = 1'b1;
      mem_addr_o = clr_cnt_q;
    end else if (gnt[REQ_A]) begin
      mem_w_en_o   = req.a_we_i;
      mem_r_en_o   = ~req.a_we_i;
      mem_addr_o   = req.a_addr_i;
      mem_w_data_o = req.a_wdata_i;
    end else if (gnt[REQ_B]) begin
      mem_w_en_o   = req.b_we_i;
      mem_r_en_o   = ~req.b_we_i;
      mem_addr_o   = req.b_addr_i;
      mem_w_data_o = req.b_wdata_i;
    end
  end

  // One-hot tag of which requester owns the RAM data arriving next cycle.
  assign rsp_d = {gnt[REQ_B] & ~req.b_we_i, gnt[REQ_A] & ~req.a_we_i};

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) rsp_q <= 2'b00;
    else        rsp_q <= rsp_d;
  end

  assign req.a_ready_o  = gnt[REQ_A];
  assign req.b_ready_o  = gnt[REQ_B];
  assign req.a_rvalid_o = rsp_q[REQ_A];
  assign req.b_rvalid_o = rsp_q[REQ_B];
  assign req.a_rdata_o  = rsp_q[REQ_A] ? mem_r_data_i : '0;
  assign req.b_rdata_o  = rsp_q[REQ_B] ? mem_r_data_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_iob_ram_t2p_tiled_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_iob_ram_t2p_tiled_arb                                                 |
// | Directed table-driven bench for iob_ram_t2p_tiled_arb with a RAM model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_iob_ram_t2p_tiled_arb;
  import iob_ram_t2p_tiled_arb_pkg::*;

  localparam int DW = 16;
  localparam int AW = 13;
  localparam logic [DW-1:0] FILL = 16'hDEAD;

  logic          clk  = 1'b0;
  logic          arst = 1'b1;
  logic          mem_w_en;
  logic          mem_r_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd = '0;
  logic          init_done;

  always #5 clk = ~clk;

  iob_ram_t2p_tiled_arb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  iob_ram_t2p_tiled_arb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .req          (bus),
    .mem_w_en_o   (mem_w_en),
    .mem_r_en_o   (mem_r_en),
    .mem_addr_o   (mem_addr),
    .mem_w_data_o (mem_wd),
    .mem_r_data_i (mem_rd),
    .init_done_o  (init_done)
  );

  // RAM model: 1-cycle read latency, 0 when not read, FILL for never-written words.
  logic [DW-1:0] ram [0:MEM_DEPTH-1];
  bit            vld [0:MEM_DEPTH-1];
  logic          bd_we   = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) begin
      ram[bd_addr] <= bd_data;
      vld[bd_addr] <= 1'b1;
    end else if (mem_w_en) begin
      ram[mem_addr] <= mem_wd;
      vld[mem_addr] <= 1'b1;
    end
    mem_rd <= mem_r_en ? (vld[mem_addr] ? ram[mem_addr] : FILL) : '0;
  end

  typedef struct {
    string         name;
    logic          av, awe;
    logic [AW-1:0] aaddr;
    logic [DW-1:0] awd;
    logic          bv, bwe;
    logic [AW-1:0] baddr;
    logic [DW-1:0] bwd;
    logic [1:0]    rdy;      // {b_ready, a_ready}
    logic          wen, ren;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwd;
    logic [1:0]    rv;       // {b_rvalid, a_rvalid}
    logic [DW-1:0] ard, brd;
  } vec_t;

  vec_t vq[$];
  int   n_tot = 0;
  int   n_pass = 0;
  int   ga = 0;
  int   gb = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, exp);
  endtask

  function automatic logic [66:0] obs();
    return {bus.b_ready_o, bus.a_ready_o, mem_w_en, mem_r_en, mem_addr, mem_wd,
            bus.b_rvalid_o, bus.a_rvalid_o, bus.a_rdata_o, bus.b_rdata_o};
  endfunction

  task automatic drive(input logic av, awe, input int aaddr, awd,
                       input logic bv, bwe, input int baddr, bwd);
    bus.a_valid_i = av;  bus.a_we_i = awe;
    bus.a_addr_i  = AW'(aaddr); bus.a_wdata_i = DW'(awd);
    bus.b_valid_i = bv;  bus.b_we_i = bwe;
    bus.b_addr_i  = AW'(baddr); bus.b_wdata_i = DW'(bwd);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic add(input string nm,
                     input logic av, awe, input int aaddr, awd,
                     input logic bv, bwe, input int baddr, bwd,
                     input logic [1:0] rdy, input logic wen, ren, input int maddr, mwd,
                     input logic [1:0] rv, input int ard, brd);
    vec_t v;
    v.name = nm;
    v.av = av; v.awe = awe; v.aaddr = AW'(aaddr); v.awd = DW'(awd);
    v.bv = bv; v.bwe = bwe; v.baddr = AW'(baddr); v.bwd = DW'(bwd);
    v.rdy = rdy; v.wen = wen; v.ren = ren; v.maddr = AW'(maddr); v.mwd = DW'(mwd);
    v.rv = rv; v.ard = DW'(ard); v.brd = DW'(brd);
    vq.push_back(v);
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive(vq[i].av, vq[i].awe, int'(vq[i].aaddr), int'(vq[i].awd),
            vq[i].bv, vq[i].bwe, int'(vq[i].baddr), int'(vq[i].bwd));
      #3;
      chk(vq[i].name, 128'(obs()),
          128'({vq[i].rdy, vq[i].wen, vq[i].ren, vq[i].maddr, vq[i].mwd,
                vq[i].rv, vq[i].ard, vq[i].brd}));
      if (bus.a_ready_o) ga++;
      if (bus.b_ready_o) gb++;
    end
    @(posedge clk); #1;
    idle();
    vq.delete();
  endtask

  task automatic wait_init();
    for (int k = 0; k < 9000 && !init_done; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    idle();
    @(posedge clk); #1; arst = 1'b1;
    @(posedge clk); #1; arst = 1'b0;
    wait_init();
    chk("reset init_done", 128'(init_done), 128'(1'b1));
  endtask

  task automatic backdoor(input int addr, input int data);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = AW'(addr); bd_data = DW'(data);
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    logic seen_rdy, wen_all;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", 128'(obs()), 128'(0));

`ifdef IOB_RAM_T2P_TILED_ARB_CLEAR_EN
    arst = 1'b0;
    drive(1'b1, 1'b0, 3, 0, 1'b1, 1'b0, 4, 0);
    cyc = 0; seen_rdy = 1'b0; wen_all = 1'b1;
    while (!init_done && cyc < 9000) begin
      if (bus.a_ready_o || bus.b_ready_o) seen_rdy = 1'b1;
      if (!mem_w_en) wen_all = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    idle();
    chk("t5 init_done latency", 128'(cyc), 128'(8192));
    chk("t5 no ready in clear", 128'(seen_rdy), 128'(1'b0));
    chk("t5 w_en during clear", 128'(wen_all), 128'(1'b1));
    add("t5 rd 0",    1,0,0,0,    0,0,0,0, 2'b01,0,1,0,0,    2'b00,0,0);
    add("t5 rd 100",  1,0,100,0,  0,0,0,0, 2'b01,0,1,100,0,  2'b01,0,0);
    add("t5 rd 8191", 1,0,8191,0, 0,0,0,0, 2'b01,0,1,8191,0, 2'b01,0,0);
    add("t5 tail",    0,0,0,0,    0,0,0,0, 2'b00,0,0,0,0,    2'b01,0,0);
    run_vecs();
`else
    arst = 1'b0;
    #1;
    chk("t6 init_done", 128'(init_done), 128'(1'b1));
    drive(1'b1, 1'b1, 7, 99, 1'b0, 1'b0, 0, 0);
    #1;
    chk("t6 immediate grant", 128'({bus.a_ready_o, mem_w_en, mem_addr, mem_wd}),
        128'({1'b1, 1'b1, 13'd7, 16'd99}));
    @(posedge clk); #1;
    idle();
`endif

    // A only: writes 0..15 (data addr+32), then reads back.
    for (int i = 0; i < 16; i++)
      add("t1 wr", 1,1,i,i+32, 0,0,0,0, 2'b01,1,0,i,i+32, 2'b00,0,0);
    for (int i = 0; i < 16; i++)
      add("t1 rd", 1,0,i,0, 0,0,0,0, 2'b01,0,1,i,0,
          (i > 0) ? 2'b01 : 2'b00, (i > 0) ? i + 31 : 0, 0);
    add("t1 tail", 0,0,0,0, 0,0,0,0, 2'b00,0,0,0,0, 2'b01,47,0);
    run_vecs();

    // Continuous contention: strict alternation starting with A.
    do_reset();
    for (int j = 0; j < 8; j++)
      if (j % 2 == 0) add("t2 grant A", 1,1,100,16'h1111, 1,1,200,16'h2222, 2'b01,1,0,100,16'h1111, 2'b00,0,0);
      else            add("t2 grant B", 1,1,100,16'h1111, 1,1,200,16'h2222, 2'b10,1,0,200,16'h2222, 2'b00,0,0);
    ga = 0; gb = 0;
    run_vecs();
    chk("t2 grants A", 128'(ga), 128'(4));
    chk("t2 grants B", 128'(gb), 128'(4));

    // Simultaneous reads, responses tagged to their owners.
    do_reset();
    backdoor(5, 37);
    backdoor(6, 38);
    add("t3 both rd",  1,0,5,0, 1,0,6,0, 2'b01,0,1,5,0, 2'b00,0,0);
    add("t3 B rd",     0,0,0,0, 1,0,6,0, 2'b10,0,1,6,0, 2'b01,37,0);
    add("t3 B resp",   0,0,0,0, 0,0,0,0, 2'b00,0,0,0,0, 2'b10,0,38);
    run_vecs();

    // Reset lands on the response cycle of an in-flight read.
    do_reset();
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 5, 0, 1'b0, 1'b0, 0, 0);
    #3;
    chk("t4 read granted", 128'(bus.a_ready_o), 128'(1'b1));
    @(posedge clk); #1;
    idle();
    arst = 1'b1;
    #1;
    chk("t4 outputs under reset", 128'(obs()), 128'(0));
    @(posedge clk); #1;
    arst = 1'b0;
    wait_init();
    chk("t4 no rvalid after reset", 128'({bus.b_rvalid_o, bus.a_rvalid_o}), 128'(0));
    drive(1'b1, 1'b0, 1, 0, 1'b1, 1'b0, 2, 0);
    #1;
    chk("t4 pointer at A", 128'({bus.b_ready_o, bus.a_ready_o}), 128'(2'b01));
    @(posedge clk); #1;
    idle();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
